serial_deserializer: RTL and testbench

- Serial-in, parallel-out capture stage that sits directly downstream of the edge-triggered D flip-flop sampling stage.
- Consumes the flop's registered Q as a serial bit stream, qualified by a bit strobe.
- Assembles WIDTH-bit words and presents each word on a valid/ready output with overrun detection.
- Frames are armed by an explicit start strobe.

---
 rtl/serial_deserializer_if.sv | 25 ++
 rtl/serial_deserializer.sv | 96 +++++++++
 tb/tb_serial_deserializer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
// Stream/handshake bundle for serial_deserializer: serial bit input side plus the
// valid/ready word output side.
interface serial_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sin;
    logic             sin_vld;
    logic             start;
    logic             dout_rdy;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             busy;
    logic             ovf;

    modport master (
        output sin, sin_vld, start, dout_rdy, clr_err,
        input  dout, dout_vld, busy, ovf
    );

    modport slave (
        input  sin, sin_vld, start, dout_rdy, clr_err,
        output dout, dout_vld, busy, ovf
    );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out capture stage: start-armed frames of WIDTH bits are shifted in
// and handed to a valid/ready holding register with sticky overrun detection.
module serial_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                 CP,
    input logic                 rst,
    serial_deserializer_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_t;

    state_t           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             busy_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sreg_shift;
    logic             hold_free;

    always_comb begin
        sreg_shift = '0;
        if (MSB_FIRST) begin
            sreg_shift = {sreg_q[WIDTH-2:0], bus.sin};
        end else begin
            sreg_shift = {bus.sin, sreg_q[WIDTH-1:1]};
        end
    end

    // The holding register can take a new word if empty or being drained on this edge.
    assign hold_free = !dout_vld_q || bus.dout_rdy;

    always_ff @(posedge CP) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sreg_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (dout_vld_q && bus.dout_rdy) begin
                dout_vld_q <= 1'b0;
            end
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StShift;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sreg_q  <= '0;
                    end
                end
                StShift: begin
                    if (bus.start) begin
                        cnt_q  <= '0;
                        sreg_q <= '0;
                    end else if (bus.sin_vld) begin
                        sreg_q <= sreg_shift;
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            // Later assignments win, so a load overrides the drain above
                            // and an overrun overrides clr_err.
                            if (hold_free) begin
                                dout_q     <= sreg_shift;
                                dout_vld_q <= 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// Bench: two DUTs (MSB-first and LSB-first) driven by one stimulus stream and compared
// every cycle against a frame-level reference model.
module tb_serial_deserializer;
    localparam int unsigned W = 8;

    logic CP = 1'b0;
    logic rst, sin, sin_vld, start, dout_rdy, clr_err;

    int checks = 0;
    int errors = 0;

    serial_deserializer_if #(.WIDTH(W)) bus_m ();
    serial_deserializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.sin = sin;      assign bus_l.sin = sin;
    assign bus_m.sin_vld = sin_vld; assign bus_l.sin_vld = sin_vld;
    assign bus_m.start = start;  assign bus_l.start = start;
    assign bus_m.dout_rdy = dout_rdy; assign bus_l.dout_rdy = dout_rdy;
    assign bus_m.clr_err = clr_err; assign bus_l.clr_err = clr_err;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.CP(CP), .rst(rst), .bus(bus_m));
    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.CP(CP), .rst(rst), .bus(bus_l));

    always #5 CP = ~CP;

    // Reference model: frame-level view (armed flag + queue of received bits).
    bit       armed;
    bit       bits[$];
    bit [W-1:0] hold_m, hold_l;
    bit       hold_v, err;

    function automatic bit [W-1:0] word_msb();
        bit [W-1:0] w = '0;
        foreach (bits[i]) w = (w << 1) | W'(bits[i]);
        return w;
    endfunction

    function automatic bit [W-1:0] word_lsb();
        bit [W-1:0] w = '0;
        foreach (bits[i]) w = w | (W'(bits[i]) << i);
        return w;
    endfunction

    task automatic model_edge();
        bit free;
        bit done = 1'b0;
        bit [W-1:0] wm, wl;
        if (rst) begin
            armed = 0; bits.delete(); hold_m = '0; hold_l = '0; hold_v = 0; err = 0;
            return;
        end
        free = !hold_v || dout_rdy;
        if (hold_v && dout_rdy) hold_v = 0;
        if (armed) begin
            if (start) bits.delete();
            else if (sin_vld) begin
                bits.push_back(sin);
                if (bits.size() == W) begin
                    done = 1'b1; wm = word_msb(); wl = word_lsb();
                    bits.delete(); armed = 0;
                end
            end
        end else if (start) begin
            armed = 1; bits.delete();
        end
        if (clr_err) err = 0;
        if (done) begin
            if (free) begin hold_m = wm; hold_l = wl; hold_v = 1; end
            else err = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("busy_m", 32'(bus_m.busy), 32'(armed));
        check("busy_l", 32'(bus_l.busy), 32'(armed));
        check("vld_m", 32'(bus_m.dout_vld), 32'(hold_v));
        check("vld_l", 32'(bus_l.dout_vld), 32'(hold_v));
        check("dout_m", 32'(bus_m.dout), 32'(hold_m));
        check("dout_l", 32'(bus_l.dout), 32'(hold_l));
        check("ovf_m", 32'(bus_m.ovf), 32'(err));
        check("ovf_l", 32'(bus_l.ovf), 32'(err));
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit st, input bit rdy,
                        input bit ce);
        rst = r; sin = s; sin_vld = v; start = st; dout_rdy = rdy; clr_err = ce;
        @(posedge CP);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit gaps, input bit rdy,
                              input bit last_rdy);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 3)) step(0, 1'($urandom), 0, 0, rdy, 0);
            step(0, b[i], 1, 0, (i == 0) ? last_rdy : rdy, 0);
        end
    endtask

    initial begin
        rst = 1; sin = 0; sin_vld = 0; start = 0; dout_rdy = 0; clr_err = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset mid-frame
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("rst_dout", 32'(bus_m.dout), 32'h0);
        check("rst_vld", 32'(bus_m.dout_vld), 32'h0);
        check("rst_busy", 32'(bus_m.busy), 32'h0);
        check("rst_ovf", 32'(bus_m.ovf), 32'h0);

        // A5 MSB-first, held until dout_rdy
        step(0, 0, 0, 1, 0, 0);
        send_frame(8'hA5, 0, 0, 0);
        check("a5_dout", 32'(bus_m.dout), 32'hA5);
        check("a5_vld", 32'(bus_m.dout_vld), 32'h1);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("a5_hold", 32'(bus_m.dout), 32'hA5);
        step(0, 0, 0, 0, 1, 0);
        check("a5_drop", 32'(bus_m.dout_vld), 32'h0);
        check("a5_keep", 32'(bus_m.dout), 32'hA5);

        // Bit on the start cycle is ignored; random gaps with garbage
        step(0, 1, 1, 1, 1, 0);
        send_frame(8'h3C, 1, 1, 1);
        check("gap_dout", 32'(bus_m.dout), 32'h3C);
        step(0, 0, 0, 0, 1, 0);

        // Restart
        step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        send_frame(8'h0F, 0, 1, 1);
        check("rs_dout", 32'(bus_m.dout), 32'h0F);
        check("rs_busy", 32'(bus_m.busy), 32'h0);
        step(0, 0, 0, 0, 1, 0);

        // Overrun then clear
        step(0, 0, 0, 1, 0, 0);
        send_frame(8'hA5, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        send_frame(8'h0F, 0, 0, 0);
        check("ov_dout", 32'(bus_m.dout), 32'hA5);
        check("ov_flag", 32'(bus_m.ovf), 32'h1);
        step(0, 0, 0, 0, 0, 1);
        check("ov_clr", 32'(bus_m.ovf), 32'h0);
        step(0, 0, 0, 1, 0, 0);
        send_frame(8'h0F, 0, 0, 1);
        check("ov2_dout", 32'(bus_m.dout), 32'h0F);
        check("ov2_flag", 32'(bus_m.ovf), 32'h0);
        step(0, 0, 0, 0, 1, 0);

        // Bit order
        step(0, 0, 0, 1, 0, 0);
        send_frame(8'h80, 0, 0, 0);
        check("ord_msb", 32'(bus_m.dout), 32'h80);
        check("ord_lsb", 32'(bus_l.dout), 32'h01);
        step(0, 0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
